// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file writeback formatter.
// Aligns load data, suppresses $zero writes, and counts retired instructions.
module writeback_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_regWrite,
    input  logic        mem_memToReg,
    input  logic [2:0]  mem_loadType,
    input  logic [1:0]  mem_byteOffset,
    input  logic [4:0]  mem_writeRegister,
    input  logic [31:0] mem_aluResult,
    input  logic [31:0] mem_readData,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic        regWrite,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic [31:0] retired
);

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memToReg;
        logic [2:0]  loadType;
        logic [1:0]  byteOffset;
        logic [4:0]  writeRegister;
        logic [31:0] aluResult;
        logic [31:0] readData;
    } mem_wb_t;

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    mem_wb_t     wb;
    mem_wb_t     mem_in;
    logic        fired;
    logic [31:0] retired_q;
    logic        retire_now;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        mem_in               = '0;
        mem_in.valid         = mem_valid;
        mem_in.regWrite      = mem_regWrite;
        mem_in.memToReg      = mem_memToReg;
        mem_in.loadType      = mem_loadType;
        mem_in.byteOffset    = mem_byteOffset;
        mem_in.writeRegister = mem_writeRegister;
        mem_in.aluResult     = mem_aluResult;
        mem_in.readData      = mem_readData;
    end

    // Each resident instruction retires exactly once, on its first edge.
    assign retire_now = wb.valid & ~fired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb        <= '0;
            fired     <= 1'b0;
            retired_q <= '0;
        end else begin
            if (retire_now) begin
                retired_q <= retired_q + 32'd1;
            end
            if (flush) begin
                wb.valid <= 1'b0;
                fired    <= 1'b0;
            end else if (stall) begin
                if (retire_now) begin
                    fired <= 1'b1;
                end
            end else begin
                wb    <= mem_in;
                fired <= 1'b0;
            end
        end
    end

    always_comb begin
        shifted = wb.readData >> {wb.byteOffset, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = wb.byteOffset[1] ? wb.readData[31:16]
                                   : wb.readData[15:0];
        unique case (wb.loadType)
            LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU:  ld_data = {24'd0, ld_byte};
            LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LT_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = wb.readData;
        endcase
    end

    assign writeData     = wb.memToReg ? ld_data : wb.aluResult;
    assign writeRegister = wb.writeRegister;
    assign fwd_valid     = wb.valid & wb.regWrite
                         & (wb.writeRegister != 5'd0);
    assign regWrite      = fwd_valid & ~fired;
    assign fwd_reg       = wb.writeRegister;
    assign fwd_data      = writeData;
    assign retired       = retired_q;

endmodule
